// File: rtl/decoder_3x8_seq_pkg.sv
// Shared constants for the 3-to-8 decoder and its 8-to-3 encoder counterpart.
// This file holds the state encodings, FIFO depth, code/data widths and the one-hot decode helper.
package decoder_3x8_seq_pkg;

    localparam int unsigned CodeW     = 3;
    localparam int unsigned DataW     = 8;
    localparam int unsigned FifoDepth = 2;

    typedef enum logic [1:0] {
        StPass  = 2'd0,
        StDrain = 2'd1,
        StScan  = 2'd2
    } state_e;

    function automatic logic [DataW-1:0] decode_onehot(input logic [CodeW-1:0] code);
        logic [DataW-1:0] word;
        word = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/decoder_3x8_seq_if.sv
// Valid/ready bundle for decoder_3x8_seq.
// The slave modport is the decoder side and the master modport is the source/sink side.
interface decoder_3x8_seq_if;
    import decoder_3x8_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [CodeW-1:0] in_code;
    logic             out_valid;
    logic             out_ready;
    logic [DataW-1:0] out_data;
    logic             scan_req;

    modport master (
        output in_valid, in_code, out_ready, scan_req,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_code, out_ready, scan_req,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/decoder_3x8_seq_fifo2.sv
// decoder_fifo2: a 2-entry FIFO of 3-bit codes with registered count and 1-bit wrapping pointers.
// A push while full and a pop while empty are both ignored.
module decoder_fifo2
    import decoder_3x8_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [CodeW-1:0] wdata_i,
    output logic [CodeW-1:0] head_o,
    output logic [1:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [CodeW-1:0] mem_q [FifoDepth];
    logic [CodeW-1:0] mem_d [FifoDepth];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == 2'(FifoDepth));
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/decoder_3x8_seq.sv
// Sequential 3-to-8 decoder: buffers codes in decoder_fifo2 and presents them as one-hot words.
// Define DECODER_SCAN_EN to compile in the walking-one scan mode (DRAIN/SCAN states, STEP dwell).
module decoder_3x8_seq
    import decoder_3x8_seq_pkg::*;
#(
    parameter int unsigned STEP = 5
) (
    input logic              clk,
    input logic              rst_n,
    decoder_3x8_seq_if.slave bus
);

    logic [CodeW-1:0] fifo_head;
    logic [1:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             in_scan;
    logic [CodeW-1:0] code;

    decoder_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.in_code),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef DECODER_SCAN_EN
    localparam logic [7:0] DwellLast = 8'(STEP - 1);

    state_e           state_q, state_d;
    logic [CodeW-1:0] scan_code_q, scan_code_d;
    logic [7:0]       dwell_q, dwell_d;
    logic             out_hs;

    assign out_hs = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        scan_code_d = scan_code_q;
        dwell_d     = dwell_q;
        case (state_q)
            StPass: begin
                if (bus.scan_req) state_d = StDrain;
            end
            StDrain: begin
                // Abort wins over entry if both apply in the same cycle.
                if (!bus.scan_req) begin
                    state_d = StPass;
                end else if (fifo_count == 2'd0) begin
                    state_d     = StScan;
                    scan_code_d = '0;
                    dwell_d     = '0;
                end
            end
            StScan: begin
                if (out_hs) begin
                    if (!bus.scan_req) begin
                        state_d = StPass;
                    end else if (dwell_q == DwellLast) begin
                        dwell_d     = '0;
                        scan_code_d = scan_code_q + 3'd1;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
            end
            default: state_d = StPass;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPass;
            scan_code_q <= '0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            scan_code_q <= scan_code_d;
            dwell_q     <= dwell_d;
        end
    end

    assign in_scan       = (state_q == StScan);
    assign bus.in_ready  = (state_q == StPass) && !bus.scan_req && !fifo_full;
    assign bus.out_valid = in_scan || !fifo_empty;
    assign code          = in_scan ? scan_code_q : fifo_head;
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.scan_req, fifo_count, STEP[0]};

    assign in_scan       = 1'b0;
    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign code          = fifo_head;
`endif

    assign push = bus.in_valid && bus.in_ready;
    // Scan words are generated, not stored, so a scan handshake never pops.
    assign pop  = bus.out_valid && bus.out_ready && !in_scan;

    assign bus.out_data = bus.out_valid ? decode_onehot(code) : '0;

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Directed self-checking bench for decoder_3x8_seq; scan-mode steps compile only with
// DECODER_SCAN_EN, otherwise scan_req is toggled to show it has no effect.
module tb_decoder_3x8_seq;

    localparam int unsigned STEP = 5;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] onehot_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    decoder_3x8_seq_if bus ();

    decoder_3x8_seq #(
        .STEP (STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic vld, input logic [7:0] data);
        chk({tag, "_in_ready"}, {7'd0, bus.in_ready}, {7'd0, rdy});
        chk({tag, "_out_valid"}, {7'd0, bus.out_valid}, {7'd0, vld});
        chk({tag, "_out_data"}, bus.out_data, data);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = 3'd0;
        bus.out_ready = 1'b0;
        bus.scan_req  = 1'b0;

        // Reset state
        @(negedge clk);
        chk_out("reset", 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("post_reset", 1'b1, 1'b0, 8'h00);

        // Pass-through: codes 0..7 back-to-back
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_code = 3'(i);
            @(negedge clk);
            chk("pass_data", bus.out_data, onehot_exp[i]);
            chk("pass_ready", {7'd0, bus.in_ready}, 8'h01);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_out("pass_idle", 1'b1, 1'b0, 8'h00);

        // Backpressure: 3 and 5 accepted, 6 stalls while full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_code   = 3'd3;
        @(negedge clk);
        chk_out("bp_one", 1'b1, 1'b1, 8'h08);
        bus.in_code = 3'd5;
        @(negedge clk);
        chk_out("bp_full", 1'b0, 1'b1, 8'h08);
        bus.in_code = 3'd6;
        @(negedge clk);
        chk_out("bp_stall", 1'b0, 1'b1, 8'h08);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk_out("bp_drain5", 1'b1, 1'b1, 8'h20);
        @(negedge clk);
        chk_out("bp_drain6", 1'b1, 1'b1, 8'h40);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_out("bp_empty", 1'b1, 1'b0, 8'h00);

        // Reset mid-stream with a full FIFO
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_code   = 3'd2;
        @(negedge clk);
        bus.in_code = 3'd4;
        @(negedge clk);
        chk_out("pre_rst", 1'b0, 1'b1, 8'h04);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk_out("mid_rst", 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("after_rst", 1'b1, 1'b0, 8'h00);

`ifdef DECODER_SCAN_EN
        // Scan walk from an empty FIFO
        bus.out_ready = 1'b1;
        bus.scan_req  = 1'b1;
        @(negedge clk);
        chk_out("scan_drain", 1'b0, 1'b0, 8'h00);
        for (int k = 0; k <= 8 * STEP; k++) begin
            @(negedge clk);
            chk("scan_walk", bus.out_data, onehot_exp[(k / STEP) % 8]);
        end
        bus.scan_req = 1'b0;
        @(negedge clk);
        chk_out("scan_exit", 1'b1, 1'b0, 8'h00);

        // Drain two queued codes before the walk starts
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_code   = 3'd1;
        @(negedge clk);
        bus.in_code = 3'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.scan_req = 1'b1;
        @(negedge clk);
        chk_out("drain_hold", 1'b0, 1'b1, 8'h02);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk_out("drain_second", 1'b0, 1'b1, 8'h80);
        @(negedge clk);
        chk_out("drain_empty", 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk_out("drain_scan0", 1'b0, 1'b1, 8'h01);
        bus.out_ready = 1'b0;
        bus.scan_req  = 1'b0;
        @(negedge clk);
        chk_out("exit_hold", 1'b0, 1'b1, 8'h01);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk_out("exit_pass", 1'b1, 1'b0, 8'h00);
`else
        // scan_req toggled during traffic has no effect
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.scan_req = ~bus.scan_req;
            bus.in_code  = 3'(7 - i);
            @(negedge clk);
            chk_out("noscan", 1'b1, 1'b1, onehot_exp[7 - i]);
        end
        bus.in_valid = 1'b0;
        bus.scan_req = 1'b0;
        @(negedge clk);
        chk_out("noscan_idle", 1'b1, 1'b0, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
